tx_burst_framer: RTL and testbench

TX_BURST_FRAMER -- requirements
Module: tx_burst_framer

---
 rtl/tx_burst_framer.sv | 198 +++++++++++++++++++
 tb/tb_tx_burst_framer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_burst_framer.sv
// Buffers 64-bit payload words and frames them into fixed-size bursts led by control words.
// Define FRAMER_CHECKSUM_EN to report a bytewise XOR checksum of each burst in the trailer.
module tx_burst_framer #(
  parameter int BURST_WORDS = 8,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET,
  input  logic [63:0] TX_DATA_IN,
  input  logic        TX_DATA_VALID,
  output logic        DATA_IN_READY,
  input  logic        GT_READY_IN,
  output logic [63:0] FRAMED_DATA_OUT,
  output logic [1:0]  FRAMED_HEADER_OUT,
  output logic        FRAMED_VALID_OUT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CTRL = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam logic [1:0]    HDR_DATA  = 2'b01;
  localparam logic [1:0]    HDR_CTRL  = 2'b10;
  localparam logic [7:0]    BURST_LEN = 8'(BURST_WORDS);
  localparam logic [7:0]    LAST_BEAT = 8'(BURST_WORDS - 1);
  localparam logic [CW-1:0] BURST_OCC = CW'(BURST_WORDS);
  localparam logic [CW-1:0] READY_MAX = CW'(FIFO_DEPTH - 2);

  logic [63:0]   fifoMemQ [FIFO_DEPTH];
  logic [AW-1:0] wrPtrQ, rdPtrQ;
  logic [CW-1:0] countQ, countD;
  logic          readyQ, readyDlyQ;
  logic          wrEn, rdEn;
  logic [63:0]   headWord;

  logic [1:0]  stateQ, stateD;
  logic [7:0]  seqQ, seqD;
  logic [7:0]  trailCntQ, trailCntD;
  logic [7:0]  beatQ, beatD;
  logic [7:0]  trailCs;
  logic        lastBeat;
  logic [63:0] ctrlWord;
  logic [63:0] dataOutQ, dataOutD;
  logic [1:0]  hdrOutQ, hdrOutD;
  logic        validOutQ;

  // Upstream answers a ready one cycle late, so the write enable uses the delayed ready.
  assign wrEn     = TX_DATA_VALID && readyDlyQ;
  assign rdEn     = GT_READY_IN && (stateQ == DATA);
  assign headWord = fifoMemQ[rdPtrQ];
  assign countD   = countQ + CW'(wrEn) - CW'(rdEn);
  assign lastBeat = (stateQ == DATA) && (beatQ == LAST_BEAT);

  assign DATA_IN_READY     = readyQ;
  assign FRAMED_DATA_OUT   = dataOutQ;
  assign FRAMED_HEADER_OUT = hdrOutQ;
  assign FRAMED_VALID_OUT  = validOutQ;

  always_ff @(posedge USER_CLK) begin
    if (wrEn) begin
      fifoMemQ[wrPtrQ] <= TX_DATA_IN;
    end
  end

  // Ready demands two free slots so the word already in flight always has room.
  always_ff @(posedge USER_CLK) begin
    readyDlyQ <= readyQ;
    if (SYSTEM_RESET) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
      readyQ <= 1'b0;
    end else begin
      if (wrEn) begin
        wrPtrQ <= wrPtrQ + AW'(1);
      end
      if (rdEn) begin
        rdPtrQ <= rdPtrQ + AW'(1);
      end
      countQ <= countD;
      readyQ <= (countD <= READY_MAX);
    end
  end

`ifdef FRAMER_CHECKSUM_EN
  logic [7:0] csAccQ, csAccD;
  logic [7:0] trailCsQ, trailCsD;
  logic [7:0] headXor;

  always_comb begin
    headXor = 8'h00;
    for (int b = 0; b < 8; b++) begin
      headXor = headXor ^ headWord[8*b +: 8];
    end
  end

  always_comb begin
    csAccD   = csAccQ;
    trailCsD = trailCsQ;
    if (GT_READY_IN) begin
      case (stateQ)
        IDLE: trailCsD = 8'h00;
        CTRL: begin
          trailCsD = 8'h00;
          csAccD   = 8'h00;
        end
        DATA: begin
          csAccD = csAccQ ^ headXor;
          if (lastBeat) begin
            trailCsD = csAccQ ^ headXor;
          end
        end
        default: csAccD = 8'h00;
      endcase
    end
  end

  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      csAccQ   <= 8'h00;
      trailCsQ <= 8'h00;
    end else begin
      csAccQ   <= csAccD;
      trailCsQ <= trailCsD;
    end
  end

  assign trailCs = trailCsQ;
`else
  assign trailCs = 8'h00;
`endif

  assign ctrlWord = {1'b1, (stateQ == CTRL), 6'd0, trailCntQ, trailCs, seqQ, 32'd0};

  // Trailer fields are reported by whichever control word follows a burst, then cleared.
  always_comb begin
    stateD    = stateQ;
    seqD      = seqQ;
    trailCntD = trailCntQ;
    beatD     = beatQ;
    dataOutD  = dataOutQ;
    hdrOutD   = hdrOutQ;
    if (GT_READY_IN) begin
      case (stateQ)
        IDLE: begin
          dataOutD  = ctrlWord;
          hdrOutD   = HDR_CTRL;
          trailCntD = 8'd0;
          if (countQ >= BURST_OCC) begin
            stateD = CTRL;
          end
        end
        CTRL: begin
          dataOutD  = ctrlWord;
          hdrOutD   = HDR_CTRL;
          trailCntD = 8'd0;
          seqD      = seqQ + 8'd1;
          beatD     = 8'd0;
          stateD    = DATA;
        end
        DATA: begin
          dataOutD = headWord;
          hdrOutD  = HDR_DATA;
          beatD    = beatQ + 8'd1;
          if (lastBeat) begin
            trailCntD = BURST_LEN;
            stateD    = (countD >= BURST_OCC) ? CTRL : IDLE;
          end
        end
        default: stateD = IDLE;
      endcase
    end
  end

  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      stateQ    <= IDLE;
      seqQ      <= 8'd0;
      trailCntQ <= 8'd0;
      beatQ     <= 8'd0;
      dataOutQ  <= 64'd0;
      hdrOutQ   <= 2'b00;
      validOutQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      seqQ      <= seqD;
      trailCntQ <= trailCntD;
      beatQ     <= beatD;
      dataOutQ  <= dataOutD;
      hdrOutQ   <= hdrOutD;
      validOutQ <= GT_READY_IN;
    end
  end

endmodule

// File: tb/tb_tx_burst_framer.sv
// Scoreboard bench for tx_burst_framer: accepted payload is queued and matched against framed output,
// while a word-level model tracks sequence numbers, trailers and burst boundaries.
`timescale 1ns/1ps
module tb_tx_burst_framer;

  localparam int BW    = 8;
  localparam int DEPTH = 16;

  logic        USER_CLK = 1'b0;
  logic        SYSTEM_RESET = 1'b1;
  logic [63:0] TX_DATA_IN = 64'd0;
  logic        TX_DATA_VALID = 1'b0;
  logic        DATA_IN_READY;
  logic        GT_READY_IN = 1'b1;
  logic [63:0] FRAMED_DATA_OUT;
  logic [1:0]  FRAMED_HEADER_OUT;
  logic        FRAMED_VALID_OUT;

  tx_burst_framer #(.BURST_WORDS(BW), .FIFO_DEPTH(DEPTH)) dut (
    .USER_CLK         (USER_CLK),
    .SYSTEM_RESET     (SYSTEM_RESET),
    .TX_DATA_IN       (TX_DATA_IN),
    .TX_DATA_VALID    (TX_DATA_VALID),
    .DATA_IN_READY    (DATA_IN_READY),
    .GT_READY_IN      (GT_READY_IN),
    .FRAMED_DATA_OUT  (FRAMED_DATA_OUT),
    .FRAMED_HEADER_OUT(FRAMED_HEADER_OUT),
    .FRAMED_VALID_OUT (FRAMED_VALID_OUT)
  );

  always #5 USER_CLK = ~USER_CLK;

  int testsRun = 0;
  int testsFailed = 0;

  logic [63:0] srcQ[$];
  logic [63:0] expQ[$];
  logic [7:0]  mSeq = 8'd0;
  logic [7:0]  mTrailCnt = 8'd0;
  logic [7:0]  mTrailCs = 8'd0;
  logic [7:0]  mAcc = 8'd0;
  int          mRemain = 0;

  logic rstReq = 1'b1;
  logic gtReq = 1'b1;
  logic rstPrev = 1'b1;
  logic rstPrev2 = 1'b1;
  logic gtPrev = 1'b1;
  logic readyPrev = 1'b0;
  bit   gapEn = 1'b0;
  bit   gtRandom = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] xorBytes(input logic [63:0] w);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < 8; b++) r = r ^ w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [7:0] reportedCs(input logic [7:0] acc);
`ifdef FRAMER_CHECKSUM_EN
    return acc;
`else
    return 8'h00 & acc;
`endif
  endfunction

  // Compare what the framer shows this cycle against the word-level model.
  task automatic monitorFramer();
    logic [63:0] expWord;
    logic        isBurst;
    if (rstPrev) begin
      checkOutput("rstData", FRAMED_DATA_OUT, 64'd0);
      checkOutput("rstHdr", 64'(FRAMED_HEADER_OUT), 64'd0);
      checkOutput("rstValid", 64'(FRAMED_VALID_OUT), 64'd0);
      checkOutput("rstReady", 64'(DATA_IN_READY), 64'd0);
      expQ.delete();
      mSeq = 8'd0; mTrailCnt = 8'd0; mTrailCs = 8'd0; mAcc = 8'd0; mRemain = 0;
      return;
    end
    if (rstPrev2) checkOutput("readyAfterRst", 64'(DATA_IN_READY), 64'd1);
    checkOutput("valid", 64'(FRAMED_VALID_OUT), 64'(gtPrev));
    if (FRAMED_VALID_OUT === 1'b1) begin
      if (FRAMED_HEADER_OUT === 2'b01) begin
        checkOutput("dataInBurst", 64'(mRemain > 0), 64'd1);
        if (expQ.size() == 0) begin
          checkOutput("dataQueued", 64'(expQ.size()), 64'd1);
        end else begin
          expWord = expQ.pop_front();
          checkOutput("data", FRAMED_DATA_OUT, expWord);
          mAcc = mAcc ^ xorBytes(expWord);
        end
        if (mRemain > 0) begin
          mRemain--;
          if (mRemain == 0) begin
            mTrailCnt = 8'(BW);
            mTrailCs  = reportedCs(mAcc);
          end
        end
      end else begin
        checkOutput("ctrlHdr", 64'(FRAMED_HEADER_OUT), 64'd2);
        checkOutput("ctrlAfterBurst", 64'(mRemain), 64'd0);
        isBurst = FRAMED_DATA_OUT[62];
        if (isBurst) checkOutput("burstBuffered", 64'(expQ.size() >= BW), 64'd1);
        expWord = {1'b1, isBurst, 6'd0, mTrailCnt, mTrailCs, mSeq, 32'd0};
        checkOutput(isBurst ? "burstCtrl" : "idleCtrl", FRAMED_DATA_OUT, expWord);
        mTrailCnt = 8'd0;
        mTrailCs  = 8'd0;
        if (isBurst) begin
          mSeq    = mSeq + 8'd1;
          mRemain = BW;
          mAcc    = 8'd0;
        end
      end
    end
    if (DATA_IN_READY) checkOutput("readyFree", 64'(expQ.size() <= DEPTH - 2), 64'd1);
  endtask

  // Drive the next cycle; a word counts as written when valid meets last cycle's ready.
  task automatic applyStimulus();
    if (gtRandom) gtReq = ($urandom_range(3) != 0);
    SYSTEM_RESET = rstReq;
    GT_READY_IN  = gtReq;
    if (srcQ.size() > 0 && !(gapEn && $urandom_range(3) == 0)) begin
      TX_DATA_VALID = 1'b1;
      TX_DATA_IN    = srcQ[0];
    end else begin
      TX_DATA_VALID = 1'b0;
      TX_DATA_IN    = {$urandom, $urandom};
    end
    if (TX_DATA_VALID && readyPrev && !rstReq) expQ.push_back(srcQ.pop_front());
    rstPrev2  = rstPrev;
    rstPrev   = rstReq;
    gtPrev    = gtReq;
    readyPrev = DATA_IN_READY;
  endtask

  task automatic tick();
    @(posedge USER_CLK);
    #1;
    monitorFramer();
    applyStimulus();
  endtask

  task automatic drain(input string tag, input int maxCycles);
    int n;
    n = 0;
    while (!(srcQ.size() == 0 && expQ.size() < BW && mRemain == 0) && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput(tag, 64'(srcQ.size() == 0 && expQ.size() < BW && mRemain == 0), 64'd1);
    repeat (4) tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] base;
    int n;
    rstReq = 1'b1;
    gtReq  = 1'b1;
    repeat (3) tick();
    rstReq = 1'b0;
    repeat (12) tick();
    checkOutput("idleWord", FRAMED_DATA_OUT, 64'h8000_0000_0000_0000);

    for (int i = 1; i <= 16; i++) srcQ.push_back(64'(i));
    drain("stream16", 300);

    base = 64'h0102_0304_0506_0708;
    repeat (BW) srcQ.push_back(base);
    drain("csEqual", 300);
    for (int i = 0; i < BW; i++) srcQ.push_back((i == 3) ? 64'h0102_0304_0506_0709 : base);
    drain("csChanged", 300);

    for (int i = 0; i < 6 * BW; i++) srcQ.push_back({$urandom, $urandom});
    repeat (6) tick();
    gtReq = 1'b0;
    repeat (5) tick();
    gtReq = 1'b1;
    drain("gtStall", 600);

    gapEn = 1'b1;
    gtRandom = 1'b1;
    for (int i = 0; i < 8 * BW; i++) srcQ.push_back({$urandom, $urandom});
    drain("randomFlow", 2000);
    gapEn = 1'b0;
    gtRandom = 1'b0;
    gtReq = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 3 * BW; i++) srcQ.push_back(64'hDEAD_0000_0000_0000 | 64'(i));
    n = 0;
    while (mRemain != BW - 3 && n < 300) begin
      tick();
      n++;
    end
    checkOutput("midBurstReached", 64'(mRemain), 64'(BW - 3));
    rstReq = 1'b1;
    repeat (2) tick();
    rstReq = 1'b0;
    srcQ.delete();
    repeat (6) tick();
    checkOutput("idleAfterAbort", FRAMED_DATA_OUT, 64'h8000_0000_0000_0000);

    for (int i = 0; i < 300 * BW; i++) srcQ.push_back(64'hA500_0000_0000_0000 | 64'(i));
    drain("burst300", 6000);
    checkOutput("seqWrapped", 64'(mSeq), 64'(300 % 256));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
